// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit state encoding, also used by the ALU decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative shifter, one bit per cycle. Used only when ALU_BARREL_SHIFT_EN is undefined.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] next_val,
  output logic             done
);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [2:0]       op_q, op_d;

  // done marks the cycle whose closing edge performs the last shift.
  always_comb begin
    case (op_q)
      ALU_SLL: next_val = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRA: next_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: next_val = {1'b0, work_q[WIDTH-1:1]};
    endcase
    done    = (count_q == SHW'(1));
    work_d  = work_q;
    count_d = count_q;
    op_d    = op_q;
    if (load) begin
      work_d  = data;
      count_d = amt;
      op_d    = op;
    end else if (count_q != '0) begin
      work_d  = next_val;
      count_d = count_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      count_q <= '0;
      op_q    <= ALU_SLL;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked multicycle ALU. Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] seq_next;
  logic [SHW-1:0]   amt;
  logic             accept, long_shift, shift_load, seq_done;

  // Transfers happen on a rising edge where valid && ready; the producer holds
  // valid and data stable until then, and the consumer may drop ready at will.
  assign amt      = src_b[SHW-1:0];
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    comb_result = '0;
    case (alu_control)
      ALU_ADD: comb_result = src_a + src_b;
      ALU_SUB: comb_result = src_a - src_b;
      ALU_AND: comb_result = src_a & src_b;
      ALU_OR:  comb_result = src_a | src_b;
      ALU_SLT: comb_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: comb_result = src_a << amt;
      ALU_SRL: comb_result = src_a >> amt;
      ALU_SRA: comb_result = $unsigned($signed(src_a) >>> amt);
`else
      default: comb_result = src_a;  // zero-amount shift passes A through
`endif
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign long_shift = 1'b0;
  assign seq_done   = 1'b0;
  assign seq_next   = '0;
  assign busy       = 1'b0;
`else
  assign long_shift = is_shift_op(alu_control) && (amt != '0);
  assign busy       = (state_q != ST_IDLE);

  alu_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_shift_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (shift_load),
    .op       (alu_control),
    .data     (src_a),
    .amt      (amt),
    .next_val (seq_next),
    .done     (seq_done)
  );
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    shift_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (long_shift) begin
            shift_load = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            result_d    = comb_result;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (seq_done) begin
          result_d    = seq_next;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with a queue-based result scoreboard.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] mon_e;
  int           mon_c;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sl(input int n);
    return BARREL ? 0 : n;
  endfunction

  // Driver: present a request, wait for acceptance, record the expected result.
  // lat = edges between the accept edge and the result edge, -1 = unchecked.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input int lat, input bit push);
    int t = 0;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept op=%0d", op);
    end else if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back((lat < 0) ? -1 : cyc + 1 + lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops on every transferred result
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%08h required=no_output", result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result", result, mon_e);
        check("zero", W'(zero), W'(mon_e == '0));
        if (mon_c >= 0) check("latency_cycle", W'(cyc), W'(mon_c));
      end
    end
  end

  initial begin
    int c0;
    int t;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    alu_control = ALU_ADD;
    src_a       = '0;
    src_b       = '0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_zero", W'(zero), 1);
    check("rst_busy", W'(busy), 0);
    check("rst_in_ready", W'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1'b1);
    send(ALU_SUB, 32'h5, 32'h5, 32'h0, 0, 1'b1);
    send(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1'b1);
    send(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 1'b1);

    send(ALU_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, sl(4), 1'b1);
    for (int i = 0; i < sl(4); i++) begin
      #1;
      check("shift_busy", W'(busy), 1);
      check("shift_in_ready", W'(in_ready), 0);
      @(negedge clk);
    end
    send(ALU_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, sl(4), 1'b1);
    send(ALU_SLL, 32'h1, 32'd31, 32'h8000_0000, sl(31), 1'b1);
    send(ALU_SLL, 32'h0000_1234, 32'h0, 32'h0000_1234, 0, 1'b1);
    send(ALU_SRA, 32'h8000_0001, 32'd32, 32'h8000_0001, 0, 1'b1);
    send(ALU_SRL, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 0, 1'b1);

    // Backpressure on an AND result, then release with a request waiting
    @(negedge clk);
    out_ready = 1'b0;
    send(ALU_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_out_valid", W'(out_valid), 1);
      check("hold_result", result, 32'h3030_3030);
      check("hold_in_ready", W'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    c0 = cyc;
    send(ALU_ADD, 32'h2, 32'h3, 32'h5, 0, 1'b1);
    check("release_same_cycle_accept", W'(cyc), W'(c0 + 1));

    // Back-to-back single-cycle ops
    send(ALU_OR, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 0, 1'b1);
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1'b1);
    send(ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1'b1);

    // Reset in the middle of a long shift
    @(negedge clk);
    send(ALU_SLL, 32'h3, 32'd20, 32'h0030_0000, sl(20), BARREL);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_busy", W'(busy), 0);
    check("midrst_result", result, 0);
    check("midrst_zero", W'(zero), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(ALU_ADD, 32'd100, 32'd23, 32'd123, 0, 1'b1);

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 3-bit ALU control code produced by the ALU decoder.
- Multicycle, handshaked ALU for the multicycle core variant.
- Add/sub/and/or/slt complete in 1 cycle; shifts (sll/srl/sra) are iterative, 1 bit per cycle.
- Input and output use valid/ready handshakes so the core FSM can stall on either side.

Parameters:
- WIDTH, 32, datapath width in bits (power of 2, >= 8).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alu_control  in  3  operation code; see Behaviour.
- src_a  in  WIDTH  operand A; shifted value for shifts.
- src_b  in  WIDTH  operand B; only bits [SHW-1:0] are used by shifts.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  high when result == 0 (combinational from the result register).
- busy  out  1  high while state != IDLE.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, result=0, zero=1, busy=0, internal count=0.
- Codes:
  - 000 add; 001 sub (a-b); 010 and; 011 or.
  - 100 sll; 101 slt (signed, result 1 or 0 zero-extended); 110 srl; 111 sra.
  - All codes are defined, so there is no illegal-op path.
- Arithmetic: add/sub wrap modulo 2^WIDTH. No overflow or carry outputs.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. A prior result may be consumed in the same cycle a new op is accepted (throughput 1 op/cycle for 1-cycle ops).
- States: IDLE, SHIFT.
- IDLE, accept of a non-shift op, or a shift with src_b[SHW-1:0]==0:
  - result is loaded at that edge; out_valid=1 next cycle; latency 1.
  - A zero-amount shift returns src_a.
- IDLE, accept of a shift with amount N>0:
  - Latch src_a into the work register, count=N, latch the shift kind; go to SHIFT.
  - Operands are not re-sampled after accept.
  - If out_valid was set and out_ready was high this cycle, out_valid clears.
- SHIFT:
  - Each cycle the work register shifts by 1 (sll: in 0 at LSB; srl: in 0 at MSB; sra: replicate MSB); count decrements.
  - At the edge where count==1: result takes the final value, out_valid=1, return to IDLE. Accept-to-out_valid latency = N cycles.
- While in SHIFT, out_valid is 0: entry to SHIFT requires that any prior result has already been consumed.
- Output hold: while out_valid && !out_ready, result and out_valid stay stable and in_ready=0.
- out_valid falls at the edge where out_ready is high and no new result is being produced.
- Reset asserted mid-SHIFT: immediate return to IDLE; the partial result is discarded and out_valid=0.
- in_valid while busy is ignored (in_ready=0). The requester must hold in_valid and its inputs stable until accepted.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally with a barrel shifter. Every op has latency 1, the SHIFT state and count are removed, and busy is tied 0.
- Undefined: iterative shifter as described above.
- Port list is identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - the 3-bit code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SLT, ALU_SRL, ALU_SRA);
  - the state enum (ST_IDLE, ST_SHIFT).
- The same code constants are to be used by the ALU decoder.
- One natural sub-module: alu_shift_seq, the iterative 1-bit-per-cycle shifter with load/start, count, and done. It is replaced by a combinational shifter when ALU_BARREL_SHIFT_EN is defined.

Test Plan:
- add a=0x7FFFFFFF, b=1, out_ready=1 -> 1 cycle later out_valid=1, result=0x80000000, zero=0; sub a=5, b=5 -> result=0, zero=1.
- slt a=0xFFFFFFFF, b=1 -> result=1; slt a=1, b=0xFFFFFFFF -> result=0.
- sra a=0x80000000, b=4 -> busy for 4 cycles, in_ready=0, then result=0xF8000000; srl same operands -> 0x08000000; sll a=1, b=31 -> 0x80000000 after 31 cycles; any shift with b=0 -> result=a, latency 1.
- Backpressure: out_ready=0 for 3 cycles after an and result -> result stable and in_ready=0 throughout; release with in_valid high -> next op accepted in the same cycle the result is consumed.
- Back-to-back or, add, sub with out_ready=1 -> 3 results on 3 consecutive cycles, in order.
- Assert rst_n=0 mid-sll (b=20, after 5 cycles) -> out_valid=0, busy=0, result=0 immediately; after release a new add is accepted and completes normally.
